// File: rtl/lcd_pkg.sv
// Shared definitions for the scoreboard character-LCD sequencer.
// Holds the top-level and byte-writer state enums, the HD44780 command bytes,
// the frame geometry and small constant helpers used to size counters.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    SNAP,
    ADDR1,
    LINE1,
    ADDR2,
    LINE2
  } lcd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_WAIT
  } wr_phase_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (long execution time)
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // entry mode: increment, no shift
  localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40

  localparam int LCD_CHARS  = 32;
  localparam int LINE_CHARS = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Initialisation command issued at position i of the INIT state.
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one HD44780 byte transaction: RS/DB set up with E low, an E pulse,
// then the post-pulse execution wait (long wait for the clear command).
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   start            accept rs/data/is_clear; transaction begins next cycle.
//                    Only asserted while idle or in the done cycle.
//   rs, data         register select and byte to send
//   is_clear         selects CLEAR_WAIT_CYC instead of CMD_WAIT_CYC
//   E, RS, DB        LCD pins; RS/DB hold until the next accepted start
//   done             1-cycle pulse on the last wait cycle
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       is_clear,
  output logic       E,
  output logic       RS,
  output logic [7:0] DB,
  output logic       done
);

  localparam int CNT_MAX = max2(max2(SETUP_CYC, E_PULSE_CYC),
                                max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);

  wr_phase_t        phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             clr;
  logic [CNT_W-1:0] wait_last;

  assign wait_last = clr ? CLEAR_LAST : CMD_LAST;
  assign done      = (phase == WR_WAIT) && (cnt == wait_last);
  // E is a pure decode of the phase register, so it drops on the reset edge.
  assign E         = (phase == WR_PULSE);

  always_comb begin
    phase_n = phase;
    cnt_n   = cnt + 1'b1;
    case (phase)
      WR_IDLE:  cnt_n = '0;
      WR_SETUP: if (cnt == SETUP_LAST) begin phase_n = WR_PULSE; cnt_n = '0; end
      WR_PULSE: if (cnt == PULSE_LAST) begin phase_n = WR_WAIT;  cnt_n = '0; end
      WR_WAIT:  if (done)              begin phase_n = WR_IDLE;  cnt_n = '0; end
      default:  begin phase_n = WR_IDLE; cnt_n = '0; end
    endcase
    // A start in the done cycle chains the next byte with no gap.
    if (start) begin
      phase_n = WR_SETUP;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= WR_IDLE;
      cnt   <= '0;
      clr   <= 1'b0;
      RS    <= 1'b0;
      DB    <= 8'h00;
    end else begin
      phase <= phase_n;
      cnt   <= cnt_n;
      if (start) begin
        RS  <= rs;
        DB  <= data;
        clr <= is_clear;
      end
    end
  end

endmodule

// File: rtl/lcd_sequencer.sv
// Scoreboard character-LCD sequencer. After reset it waits for LCD power-up,
// sends the HD44780 8-bit init sequence, then refreshes all 32 characters from
// a snapshot of the ascii frame. Later refreshes run on an update request;
// requests arriving during a refresh coalesce into one follow-up refresh.
// Handshake: update is a single-cycle request; busy is low only when the
// sequencer is idle and rises the cycle after an update is taken in idle.
// Ports:
//   clk, reset   50 MHz clock, synchronous active-low reset
//   ascii        frame, char k = ascii[255-8k -: 8]; chars 0-15 line 1
//   update       refresh request
//   busy         high while initialising or refreshing
//   E, RS, RW, DB  LCD pins (RW always 0, write-only)
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] ascii,
  input  logic         update,
  output logic         busy,
  output logic         E,
  output logic         RS,
  output logic         RW,
  output logic [7:0]   DB
);

  localparam int CNT_W = $clog2(max2(POWERUP_CYC, CLEAR_WAIT_CYC) + 1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
  localparam logic [3:0]       LAST_IDX = 4'(LINE_CHARS - 1);

  lcd_state_t       state, state_n;
  logic [3:0]       idx, idx_n;
  logic [CNT_W-1:0] pwr_cnt, cnt_n;
  logic [255:0]     frame;
  logic             active, active_n;
  logic             pending, pending_n;

  logic [7:0]       chars [LCD_CHARS];
  logic             wr_start, wr_rs, wr_clear, wr_done, is_send;
  logic [7:0]       wr_data;

  assign RW   = 1'b0;
  assign busy = (state != IDLE);

  always_comb begin
    for (int k = 0; k < LCD_CHARS; k++) chars[k] = frame[255 - 8*k -: 8];
  end

  // Next state: byte-sending states advance only on the writer's done pulse.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = '0;
    pending_n = pending;
    case (state)
      PWRUP: begin
        if (pwr_cnt == PWR_LAST) begin
          state_n = INIT;
          idx_n   = '0;
        end else begin
          cnt_n = pwr_cnt + 1'b1;
        end
      end
      INIT: begin
        if (wr_done) begin
          if (idx == 4'd3) begin state_n = SNAP; idx_n = '0; end
          else idx_n = idx + 4'd1;
        end
      end
      IDLE:  if (update) state_n = SNAP;
      SNAP:  state_n = ADDR1;
      ADDR1: if (wr_done) begin state_n = LINE1; idx_n = '0; end
      LINE1: begin
        if (wr_done) begin
          if (idx == LAST_IDX) begin state_n = ADDR2; idx_n = '0; end
          else idx_n = idx + 4'd1;
        end
      end
      ADDR2: if (wr_done) begin state_n = LINE2; idx_n = '0; end
      LINE2: begin
        if (wr_done) begin
          if (idx == LAST_IDX) begin
            idx_n = '0;
            if (pending) begin
              state_n   = SNAP;
              pending_n = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      default: begin
        state_n = PWRUP;
        idx_n   = '0;
      end
    endcase
    // Updates during power-up/init are covered by the automatic first refresh.
    // A new request wins over the pending-clear so it is never lost.
    if (update && (state inside {SNAP, ADDR1, LINE1, ADDR2, LINE2}))
      pending_n = 1'b1;
  end

  // The byte is chosen from the state being entered so the writer can be
  // restarted in the done cycle and transactions run back to back.
  always_comb begin
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    case (state_n)
      INIT:    wr_data = init_cmd(idx_n[1:0]);
      ADDR1:   wr_data = CMD_LINE1;
      LINE1:   begin wr_rs = 1'b1; wr_data = chars[{1'b0, idx_n}]; end
      ADDR2:   wr_data = CMD_LINE2;
      LINE2:   begin wr_rs = 1'b1; wr_data = chars[{1'b1, idx_n}]; end
      default: wr_data = 8'h00;
    endcase
    wr_clear = !wr_rs && (wr_data == CMD_CLEAR);
    is_send  = state_n inside {INIT, ADDR1, LINE1, ADDR2, LINE2};
    wr_start = is_send && (!active || wr_done);
    active_n = wr_start ? 1'b1 : (wr_done ? 1'b0 : active);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= PWRUP;
      idx     <= '0;
      pwr_cnt <= '0;
      frame   <= '0;
      active  <= 1'b0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pwr_cnt <= cnt_n;
      active  <= active_n;
      pending <= pending_n;
      if (state == SNAP) frame <= ascii;
    end
  end

  lcd_byte_writer #(
    .SETUP_CYC      (SETUP_CYC),
    .E_PULSE_CYC    (E_PULSE_CYC),
    .CMD_WAIT_CYC   (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
  ) u_writer (
    .clk      (clk),
    .reset    (reset),
    .start    (wr_start),
    .rs       (wr_rs),
    .data     (wr_data),
    .is_clear (wr_clear),
    .E        (E),
    .RS       (RS),
    .DB       (DB),
    .done     (wr_done)
  );

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer with short timing parameters. A queue holds the
// {RS,DB} bytes each refresh must produce; a monitor checks every cycle for
// RW, bus stability, E timing and byte order against that queue.
module tb_lcd_sequencer;

  localparam int P_PWR = 10;
  localparam int P_SET = 2;
  localparam int P_EP  = 3;
  localparam int P_CMD = 5;
  localparam int P_CLR = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         update = 1'b0;
  logic [255:0] ascii;
  logic         busy, E, RS, RW;
  logic [7:0]   DB;

  // clock/reset block
  always #5 clk = ~clk;

  lcd_sequencer #(
    .POWERUP_CYC    (P_PWR),
    .SETUP_CYC      (P_SET),
    .E_PULSE_CYC    (P_EP),
    .CMD_WAIT_CYC   (P_CMD),
    .CLEAR_WAIT_CYC (P_CLR)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ascii  (ascii),
    .update (update),
    .busy   (busy),
    .E      (E),
    .RS     (RS),
    .RW     (RW),
    .DB     (DB)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [8:0]  exp_q[$];
  bit          mon_en  = 1'b0;
  int          n_rise  = 0;

  logic [255:0] f0, f1, f2, f3;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] char_of(input logic [255:0] f, input int k);
    logic [255:0] s;
    s = f >> (8 * (31 - k));
    return s[7:0];
  endfunction

  function automatic int wait_of(input logic [8:0] b);
    return (b == 9'h001) ? P_CLR : P_CMD;
  endfunction

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic push_refresh(input logic [255:0] f);
    exp_q.push_back(9'h080);
    for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, char_of(f, k)});
    exp_q.push_back(9'h0C0);
    for (int k = 16; k < 32; k++) exp_q.push_back({1'b1, char_of(f, k)});
  endtask

  // Counts consecutive busy-high cycles from the current one; optionally
  // pulses update at busy-cycle indices p1 (also loading new_ascii) and p2.
  task automatic busy_run(input int p1, input int p2, input logic [255:0] new_ascii,
                          output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      if (n == p1) begin
        ascii  = new_ascii;
        update = 1'b1;
      end else if (n == p2) begin
        update = 1'b1;
      end else begin
        update = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    update = 1'b0;
  endtask

  // Per-cycle monitor / scoreboard.
  logic       prev_e;
  logic [8:0] prev_bus, last_b;
  int         stable, high_cnt, since_fall;
  bit         have_last;

  initial begin : monitor
    logic [8:0] bus, exp;
    bit changed;
    prev_e = 1'b0; prev_bus = '0; last_b = '0;
    stable = 0; high_cnt = 0; since_fall = 0; have_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_e = 1'b0; prev_bus = '0; stable = 0; high_cnt = 0;
        since_fall = 0; have_last = 1'b0;
      end else begin
        bus = {RS, DB};
        chk(RW === 1'b0, "rw_zero", RW, 0);
        changed = (bus !== prev_bus);
        if (changed) begin
          chk(E === 1'b0, "bus_change_while_e_high", E, 0);
          if (have_last && E === 1'b0)
            chk(since_fall >= wait_of(last_b), "bus_hold_through_wait",
                since_fall, wait_of(last_b));
          stable = 1;
        end else begin
          stable++;
        end
        if (E === 1'b1 && prev_e === 1'b0) begin
          chk(stable >= P_SET + 1, "setup_before_e", stable, P_SET + 1);
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_byte", bus, 0);
          end else begin
            exp = exp_q.pop_front();
            chk(bus === exp, "byte", bus, exp);
            // 80h follows a SNAP cycle or idle time, so its gap is not fixed.
            if (have_last && exp != 9'h080)
              chk(since_fall == wait_of(last_b) + P_SET, "gap_after_byte",
                  since_fall, wait_of(last_b) + P_SET);
          end
          last_b = bus; have_last = 1'b1; high_cnt = 1; since_fall = 0;
          n_rise++;
        end else if (E === 1'b1) begin
          high_cnt++;
        end
        if (E === 1'b0 && prev_e === 1'b1) begin
          chk(high_cnt == P_EP, "e_high_len", high_cnt, P_EP);
          since_fall = 1;
        end else if (E === 1'b0 && have_last) begin
          since_fall++;
        end
        prev_e = E; prev_bus = bus;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, base;
    bit found;
    f0 = {"P1: HU    P2: CP", "  3 LVL5     5  "};
    f1 = {"P1: CP    P2: HU", "  7 LVL5     9  "};
    f2 = {"P1: CP    P2: HU", "  8 LVL6     9  "};
    f3 = {"P1: HU    P2: CP", "  4 LVL7     2  "};
    ascii = f0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk(E === 1'b0, "rst_e", E, 0);
    chk(RS === 1'b0, "rst_rs", RS, 0);
    chk(DB === 8'h00, "rst_db", DB, 0);
    chk(busy === 1'b1, "rst_busy", busy, 1);
    chk(RW === 1'b0, "rst_rw", RW, 0);

    // Power-up, init and automatic first refresh:
    // 10 + (10+10+25+10) + 1 + 34*10 = 406 busy cycles.
    reset = 1'b1;
    mon_en = 1'b1;
    push_init();
    push_refresh(f0);
    busy_run(-1, -1, f0, n);
    chk(n == 406, "init_busy_len", n, 406);
    chk(exp_q.size() == 0, "init_bytes_all_seen", exp_q.size(), 0);

    // Single refresh from idle: 1 SNAP + 340 = 341 busy cycles.
    repeat (5) @(negedge clk);
    ascii = f1;
    update = 1'b1;
    push_refresh(f1);
    @(negedge clk);
    update = 1'b0;
    chk(busy === 1'b1, "busy_rise_after_update", busy, 1);
    busy_run(-1, -1, f1, n);
    chk(n == 341, "refresh_busy_len", n, 341);
    chk(exp_q.size() == 0, "refresh_bytes_all_seen", exp_q.size(), 0);

    // Two updates mid-refresh plus an ascii change: old snapshot, then one
    // extra refresh of the latest frame, busy continuous (2 * 341).
    repeat (4) @(negedge clk);
    ascii = f2;
    update = 1'b1;
    push_refresh(f2);
    push_refresh(f3);
    @(negedge clk);
    update = 1'b0;
    busy_run(50, 150, f3, n);
    chk(n == 682, "coalesced_busy_len", n, 682);
    repeat (40) @(negedge clk);
    chk(busy === 1'b0, "idle_after_coalesce", busy, 0);
    chk(exp_q.size() == 0, "coalesce_bytes_all_seen", exp_q.size(), 0);

    // Reset during E-high of line-1 char 5 (7th byte of the refresh).
    ascii = f0;
    update = 1'b1;
    push_refresh(f0);
    base = n_rise;
    @(negedge clk);
    update = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      if (n_rise == base + 7) begin
        found = 1'b1;
        break;
      end
    end
    chk(found, "reach_char5", n_rise - base, 7);
    chk(E === 1'b1, "e_high_at_reset", E, 1);
    mon_en = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk(E === 1'b0, "midrst_e", E, 0);
    chk(DB === 8'h00, "midrst_db", DB, 0);
    chk(RS === 1'b0, "midrst_rs", RS, 0);
    chk(busy === 1'b1, "midrst_busy", busy, 1);
    chk(RW === 1'b0, "midrst_rw", RW, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);

    // Full restart; an update during INIT must not add a refresh.
    reset = 1'b1;
    mon_en = 1'b1;
    push_init();
    push_refresh(f0);
    busy_run(20, -1, f0, n);
    chk(n == 406, "restart_busy_len", n, 406);
    repeat (30) @(negedge clk);
    chk(busy === 1'b0, "no_refresh_from_init_update", busy, 0);
    chk(exp_q.size() == 0, "restart_bytes_all_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
